alu_control_unit: RTL and testbench
===================================

Name: alu_control_unit

Overview:
- Sequencer that issues work to the 16-bit ALU.
- Fetches 8-bit instructions over a req/ack memory port and decodes them.
- Drives the ALU operation code, operand select and write enables.
- Consumes the ALU's registered zero flag for conditional jumps.
- Sits between instruction memory, the register file/AC/PC datapath and the ALU.

Parameters:
- OPW, 3, ALU operation code width.
- RSW, 4, register select width (instruction low nibble).
- IW, 8, instruction width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts a program from IDLE or HALT
- instr  in  IW  memory read data (opcode or operand byte)
- mem_ack  in  1  one-cycle pulse; completes the current mem_rd/mem_wr
- z  in  1  ALU zero flag (registered: B==0 sampled at the previous clk edge)
- alu_op  out  OPW  0=hold, 1=pass, 2=add, 3=sub(B-A), 4=lshift B, 5=rshift-round B, 6=or
- a_sel  out  RSW  register driving ALU A (B is always AC)
- ac_we  out  1  AC <= ALU C this edge
- reg_we  out  1  reg[a_sel] <= AC this edge
- pc_clr, pc_inc, pc_load  out  1 each  PC control (pc_load: PC <= instr)
- ir_load  out  1  IR <= instr
- mem_rd, mem_wr  out  1 each  memory request, held until mem_ack
- addr_sel  out  1  0=PC, 1=AR
- busy, done, error  out  1 each  status

Behaviour:
- Reset: state IDLE; every output 0. Reset mid-operation aborts immediately, including a pending memory request.
- Opcode is instr[7:4]; R is instr[3:0]:
  - 0 NOP
  - 1 MVAC (AC<=R, pass)
  - 2 ADD (AC<=AC+R)
  - 3 SUB (AC<=AC-R)
  - 4 LSH (AC<=AC<<1)
  - 5 RSH (AC<=AC>>2, rounded)
  - 6 OR
  - 7 LDAC (AC<=mem[AR])
  - 8 STAC (mem[AR]<=AC)
  - 9 JMP addr
  - A JMPZ addr
  - B MVR (R<=AC)
  - F HALT
  - C, D, E illegal
- States: IDLE, FETCH, DECODE, EXEC, MEMOP, OPFETCH, HALT.
- IDLE: on start, pc_clr=1 for one cycle, busy=1 -> FETCH.
- FETCH: mem_rd=1, addr_sel=0 until mem_ack. On the ack cycle: ir_load=1, pc_inc=1 -> DECODE.
- DECODE: drive alu_op and a_sel from IR, held through EXEC, so the ALU settles one full cycle and z registers AC. Next state:
  - EXEC for ALU ops, MVR, JMPZ, NOP.
  - MEMOP for 7 and 8.
  - OPFETCH for JMP.
  - HALT for F and illegal opcodes.
- EXEC:
  - ALU ops: ac_we=1.
  - MVR: reg_we=1, alu_op=0.
  - JMPZ: if z=1 -> OPFETCH; else pc_inc=1 (skip operand) -> FETCH.
  - All others -> FETCH.
- MEMOP: addr_sel=1; mem_rd (LDAC) or mem_wr (STAC) held until mem_ack. LDAC pulses ac_we on the ack cycle with alu_op=0 (datapath muxes memory into AC). Then -> FETCH.
- OPFETCH: mem_rd=1, addr_sel=0 until ack; pc_load=1 on the ack cycle -> FETCH.
- HALT: busy=0, done=1; error=1 if entered via an illegal opcode. Both hold until start; start clears them and restarts as from IDLE.
- Memory handshake:
  - Requests drop in the cycle after ack.
  - mem_ack outside a request is ignored.
  - mem_rd and mem_wr are never both high.
- start while busy is ignored.
- Latency: ALU instruction = FETCH(1+wait) + DECODE + EXEC, so 3 cycles with zero-wait memory.
- PC wraps modulo 256 in the datapath; the FSM is unaffected.

Decomposition:
- Shared package/include `cpu_defs`: ALU op codes (shared with the ALU), opcode nibble constants, state encoding.
- One sub-module `opcode_decoder` (combinational):
  - Input: IR.
  - Outputs: alu_op, is_alu, is_mem, is_jump, is_cond, legal.

Test Plan:
- rst high 2 cycles, then start with zero-wait ack and program 0x23,0xF0 -> pc_clr pulse; alu_op=2, a_sel=3 during DECODE/EXEC; ac_we exactly 1 cycle; done=1, error=0.
- JMPZ with AC=0: program 0xA0,0x10 -> OPFETCH reads 0x10, pc_load=1, next fetch from PC=0x10.
- JMPZ with AC=5 -> no pc_load; pc_inc in EXEC; execution continues at the byte after the operand.
- LDAC with mem_ack delayed 4 cycles -> mem_rd and addr_sel=1 held 4 cycles; ac_we only on the ack cycle; mem_rd low next cycle.
- Opcode 0xC5 -> HALT, done=1, error=1; a following start clears both and pulses pc_clr.
- rst asserted while mem_wr is pending (STAC) -> next cycle all outputs 0 and state IDLE; start while busy has no effect.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the ALU sequencer: ALU operation codes (common with the ALU),
// instruction opcode nibbles and the sequencer state encoding.
package cpu_defs;

  localparam logic [2:0] ALU_HOLD = 3'd0;
  localparam logic [2:0] ALU_PASS = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_LSH  = 3'd4;
  localparam logic [2:0] ALU_RSH  = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MVAC = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_LSH  = 4'h4;
  localparam logic [3:0] OP_RSH  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_LDAC = 4'h7;
  localparam logic [3:0] OP_STAC = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JMPZ = 4'hA;
  localparam logic [3:0] OP_MVR  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEMOP   = 3'd4,
    S_OPFETCH = 3'd5,
    S_HALT    = 3'd6
  } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational instruction classifier: maps the IR opcode nibble to an ALU
// operation and the class flags the sequencer branches on.
module opcode_decoder
  import cpu_defs::*;
#(
  parameter int OPW = 3,
  parameter int RSW = 4,
  parameter int IW  = 8
) (
  input  logic [IW-1:0]  ir,
  output logic [OPW-1:0] alu_op,
  output logic           is_alu,
  output logic           is_mem,
  output logic           is_jump,
  output logic           is_cond,
  output logic           legal
);

  logic [3:0] w_opc;
  logic       w_unused_r;

  assign w_opc      = ir[IW-1:IW-4];
  // The register nibble is routed straight to a_sel by the sequencer.
  assign w_unused_r = ^ir[RSW-1:0];

  always_comb begin
    alu_op  = ALU_HOLD;
    is_alu  = 1'b0;
    is_mem  = 1'b0;
    is_jump = 1'b0;
    is_cond = 1'b0;
    legal   = 1'b1;
    case (w_opc)
      OP_MVAC: begin alu_op = ALU_PASS; is_alu = 1'b1; end
      OP_ADD:  begin alu_op = ALU_ADD;  is_alu = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB;  is_alu = 1'b1; end
      OP_LSH:  begin alu_op = ALU_LSH;  is_alu = 1'b1; end
      OP_RSH:  begin alu_op = ALU_RSH;  is_alu = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;   is_alu = 1'b1; end
      OP_LDAC, OP_STAC: is_mem = 1'b1;
      OP_JMP:  is_jump = 1'b1;
      OP_JMPZ: begin is_jump = 1'b1; is_cond = 1'b1; end
      4'hC, 4'hD, 4'hE: legal = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_control_unit.sv
// Instruction sequencer for the 16-bit ALU datapath: fetches and decodes 8-bit
// instructions and drives ALU op, operand select, write enables and PC control.
//
// Memory handshake: mem_rd/mem_wr rise when a request starts and stay high until
// the cycle mem_ack is seen; the request drops in the following cycle. mem_ack
// is ignored when no request is outstanding. mem_rd and mem_wr are exclusive.
module alu_control_unit
  import cpu_defs::*;
#(
  parameter int OPW = 3,
  parameter int RSW = 4,
  parameter int IW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [IW-1:0]  instr,
  input  logic           mem_ack,
  input  logic           z,
  output logic [OPW-1:0] alu_op,
  output logic [RSW-1:0] a_sel,
  output logic           ac_we,
  output logic           reg_we,
  output logic           pc_clr,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           ir_load,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           addr_sel,
  output logic           busy,
  output logic           done,
  output logic           error,
  output state_t         dbg_state
);

  state_t         r_state;
  state_t         w_next;
  logic [IW-1:0]  r_ir;
  logic           r_err;

  logic [OPW-1:0] w_dec_alu_op;
  logic           w_is_alu;
  logic           w_is_mem;
  logic           w_is_jump;
  logic           w_is_cond;
  logic           w_legal;
  logic [3:0]     w_opc;
  logic           w_go;

  opcode_decoder #(.OPW(OPW), .RSW(RSW), .IW(IW)) u_dec (
    .ir      (r_ir),
    .alu_op  (w_dec_alu_op),
    .is_alu  (w_is_alu),
    .is_mem  (w_is_mem),
    .is_jump (w_is_jump),
    .is_cond (w_is_cond),
    .legal   (w_legal)
  );

  assign w_opc     = r_ir[IW-1:IW-4];
  assign w_go      = start & ~rst;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (ir_load) r_ir <= instr;
      // Error is decided at decode and survives in HALT until the next start.
      if (r_state == S_DECODE)
        r_err <= ~w_legal;
      else if (r_state == S_HALT && w_go)
        r_err <= 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_go) w_next = S_FETCH;
      S_FETCH:   if (mem_ack) w_next = S_DECODE;
      S_DECODE: begin
        if (!w_legal || w_opc == OP_HALT)  w_next = S_HALT;
        else if (w_is_mem)                 w_next = S_MEMOP;
        else if (w_is_jump && !w_is_cond)  w_next = S_OPFETCH;
        else                               w_next = S_EXEC;
      end
      S_EXEC:    w_next = (w_is_cond && z) ? S_OPFETCH : S_FETCH;
      S_MEMOP:   if (mem_ack) w_next = S_FETCH;
      S_OPFETCH: if (mem_ack) w_next = S_FETCH;
      S_HALT:    if (w_go) w_next = S_FETCH;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    alu_op   = '0;
    a_sel    = '0;
    ac_we    = 1'b0;
    reg_we   = 1'b0;
    pc_clr   = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    ir_load  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          pc_clr = 1'b1;
          busy   = 1'b1;
        end
      end
      S_FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
      end
      S_DECODE: begin
        busy   = 1'b1;
        alu_op = w_dec_alu_op;
        a_sel  = r_ir[RSW-1:0];
      end
      S_EXEC: begin
        // Op and operand are held from decode so z reflects a settled AC.
        busy   = 1'b1;
        alu_op = w_dec_alu_op;
        a_sel  = r_ir[RSW-1:0];
        ac_we  = w_is_alu;
        reg_we = (w_opc == OP_MVR);
        if (w_is_cond && !z) pc_inc = 1'b1;
      end
      S_MEMOP: begin
        busy     = 1'b1;
        addr_sel = 1'b1;
        mem_rd   = (w_opc == OP_LDAC);
        mem_wr   = (w_opc != OP_LDAC);
        if (mem_ack && w_opc == OP_LDAC) ac_we = 1'b1;
      end
      S_OPFETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (mem_ack) pc_load = 1'b1;
      end
      S_HALT: begin
        if (w_go) begin
          pc_clr = 1'b1;
          busy   = 1'b1;
        end else begin
          done  = 1'b1;
          error = r_err;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed vector bench for alu_control_unit: each record gives one cycle of
// inputs plus the expected state and outputs for that cycle.
module tb_alu_control_unit;
  import cpu_defs::*;

  localparam logic [11:0] F_ACWE  = 12'h800;
  localparam logic [11:0] F_REGWE = 12'h400;
  localparam logic [11:0] F_PCCLR = 12'h200;
  localparam logic [11:0] F_PCINC = 12'h100;
  localparam logic [11:0] F_PCLD  = 12'h080;
  localparam logic [11:0] F_IRLD  = 12'h040;
  localparam logic [11:0] F_RD    = 12'h020;
  localparam logic [11:0] F_WR    = 12'h010;
  localparam logic [11:0] F_AS    = 12'h008;
  localparam logic [11:0] F_BUSY  = 12'h004;
  localparam logic [11:0] F_DONE  = 12'h002;
  localparam logic [11:0] F_ERR   = 12'h001;
  localparam logic [11:0] F_FACK  = F_RD | F_IRLD | F_PCINC | F_BUSY;
  localparam logic [11:0] F_START = F_PCCLR | F_BUSY;

  typedef struct {
    string      name;
    logic       rst_v;
    logic       start_v;
    logic [7:0] instr_v;
    logic       ack_v;
    logic       z_v;
    state_t     es;
    logic [2:0] ea;
    logic [3:0] esel;
    logic [11:0] ef;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       mem_ack = 1'b0;
  logic       z = 1'b0;

  logic [2:0] alu_op;
  logic [3:0] a_sel;
  logic ac_we, reg_we, pc_clr, pc_inc, pc_load, ir_load;
  logic mem_rd, mem_wr, addr_sel, busy, done, error;
  state_t dbg_state;

  alu_control_unit dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .mem_ack(mem_ack), .z(z),
    .alu_op(alu_op), .a_sel(a_sel), .ac_we(ac_we), .reg_we(reg_we),
    .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_load(pc_load), .ir_load(ir_load),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic s, input logic [7:0] ins,
                     input logic a, input logic zz, input state_t es, input logic [2:0] ea,
                     input logic [3:0] esel, input logic [11:0] ef);
    vec_t v;
    v.name = name; v.rst_v = r; v.start_v = s; v.instr_v = ins; v.ack_v = a; v.z_v = zz;
    v.es = es; v.ea = ea; v.esel = esel; v.ef = ef;
    vecs.push_back(v);
  endtask

  // driver + checker: inputs change on the falling edge, outputs checked 1ns later
  task automatic step(input vec_t v);
    logic [18:0] got, exp;
    @(negedge clk);
    rst = v.rst_v; start = v.start_v; instr = v.instr_v; mem_ack = v.ack_v; z = v.z_v;
    #1;
    got = {alu_op, a_sel, ac_we, reg_we, pc_clr, pc_inc, pc_load, ir_load,
           mem_rd, mem_wr, addr_sel, busy, done, error};
    exp = {v.ea, v.esel, v.ef};
    n_vec++;
    if (got !== exp || dbg_state !== v.es) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got state=%0d out=%05h, expected state=%0d out=%05h",
               v.name, n_vec, dbg_state, got, v.es, exp);
    end
  endtask

  initial begin
    vec_t v;
    // reset, then ADD R3 / HALT with zero-wait memory
    add("rst0",      1, 0, 8'h00, 0, 0, S_IDLE,    0, 0, 12'h000);
    add("rst1",      1, 0, 8'h00, 0, 0, S_IDLE,    0, 0, 12'h000);
    add("idle",      0, 0, 8'h00, 0, 0, S_IDLE,    0, 0, 12'h000);
    add("start",     0, 1, 8'h00, 0, 0, S_IDLE,    0, 0, F_START);
    add("f_add",     0, 0, 8'h23, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_add",     0, 0, 8'h00, 0, 0, S_DECODE,  2, 3, F_BUSY);
    add("e_add",     0, 0, 8'h00, 0, 0, S_EXEC,    2, 3, F_ACWE | F_BUSY);
    add("f_halt",    0, 0, 8'hF0, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_halt",    0, 0, 8'h00, 0, 0, S_DECODE,  0, 0, F_BUSY);
    add("halt",      0, 0, 8'h00, 0, 0, S_HALT,    0, 0, F_DONE);
    add("halt_hold", 0, 0, 8'h00, 0, 0, S_HALT,    0, 0, F_DONE);
    // JMPZ taken
    add("rs_jz",     0, 1, 8'h00, 0, 0, S_HALT,    0, 0, F_START);
    add("f_jz",      0, 0, 8'hA0, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_jz",      0, 0, 8'h00, 0, 0, S_DECODE,  0, 0, F_BUSY);
    add("e_jz_t",    0, 0, 8'h00, 0, 1, S_EXEC,    0, 0, F_BUSY);
    add("opf_jz",    0, 0, 8'h10, 1, 0, S_OPFETCH, 0, 0, F_RD | F_PCLD | F_BUSY);
    add("f_wait",    0, 0, 8'h00, 0, 0, S_FETCH,   0, 0, F_RD | F_BUSY);
    add("f_halt2",   0, 0, 8'hF0, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_halt2",   0, 0, 8'h00, 0, 0, S_DECODE,  0, 0, F_BUSY);
    add("halt2",     0, 0, 8'h00, 0, 0, S_HALT,    0, 0, F_DONE);
    // JMPZ not taken, then a mix of ALU / MVR / NOP / JMP
    add("rs_jnz",    0, 1, 8'h00, 0, 0, S_HALT,    0, 0, F_START);
    add("f_jnz",     0, 0, 8'hA0, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_jnz",     0, 0, 8'h00, 0, 0, S_DECODE,  0, 0, F_BUSY);
    add("e_jnz",     0, 0, 8'h00, 0, 0, S_EXEC,    0, 0, F_PCINC | F_BUSY);
    add("f_lsh",     0, 0, 8'h45, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_lsh",     0, 0, 8'h00, 0, 0, S_DECODE,  4, 5, F_BUSY);
    add("e_lsh",     0, 0, 8'h00, 0, 0, S_EXEC,    4, 5, F_ACWE | F_BUSY);
    add("f_mvr",     0, 0, 8'hB7, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_mvr",     0, 0, 8'h00, 0, 0, S_DECODE,  0, 7, F_BUSY);
    add("e_mvr",     0, 0, 8'h00, 0, 0, S_EXEC,    0, 7, F_REGWE | F_BUSY);
    add("f_sub",     0, 0, 8'h3A, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_sub",     0, 0, 8'h00, 0, 0, S_DECODE,  3, 4'hA, F_BUSY);
    add("e_sub",     0, 0, 8'h00, 0, 0, S_EXEC,    3, 4'hA, F_ACWE | F_BUSY);
    add("f_nop",     0, 0, 8'h00, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_nop",     0, 0, 8'h00, 0, 0, S_DECODE,  0, 0, F_BUSY);
    add("e_nop",     0, 0, 8'h00, 0, 0, S_EXEC,    0, 0, F_BUSY);
    add("f_jmp",     0, 0, 8'h90, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_jmp",     0, 0, 8'h00, 0, 0, S_DECODE,  0, 0, F_BUSY);
    add("opf_jmp",   0, 0, 8'h20, 1, 0, S_OPFETCH, 0, 0, F_RD | F_PCLD | F_BUSY);
    add("f_or",      0, 0, 8'h6C, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_or",      0, 0, 8'h00, 0, 0, S_DECODE,  6, 4'hC, F_BUSY);
    add("e_or",      0, 0, 8'h00, 0, 0, S_EXEC,    6, 4'hC, F_ACWE | F_BUSY);
    add("f_rsh",     0, 0, 8'h51, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_rsh",     0, 0, 8'h00, 0, 0, S_DECODE,  5, 1, F_BUSY);
    add("e_rsh",     0, 0, 8'h00, 0, 0, S_EXEC,    5, 1, F_ACWE | F_BUSY);
    add("f_mvac",    0, 0, 8'h1F, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_mvac",    0, 0, 8'h00, 0, 0, S_DECODE,  1, 4'hF, F_BUSY);
    add("e_mvac",    0, 0, 8'h00, 0, 0, S_EXEC,    1, 4'hF, F_ACWE | F_BUSY);
    // illegal opcode, stray ack in HALT, restart
    add("f_ill",     0, 0, 8'hC5, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_ill",     0, 0, 8'h00, 0, 0, S_DECODE,  0, 5, F_BUSY);
    add("halt_err",  0, 0, 8'h00, 0, 0, S_HALT,    0, 0, F_DONE | F_ERR);
    add("halt_ack",  0, 0, 8'h00, 1, 0, S_HALT,    0, 0, F_DONE | F_ERR);
    add("rs_err",    0, 1, 8'h00, 0, 0, S_HALT,    0, 0, F_START);
    add("f_nack",    0, 0, 8'h00, 0, 0, S_FETCH,   0, 0, F_RD | F_BUSY);
    // STAC pending, start ignored while busy, reset aborts
    add("f_stac",    0, 0, 8'h80, 1, 0, S_FETCH,   0, 0, F_FACK);
    add("d_stac",    0, 0, 8'h00, 0, 0, S_DECODE,  0, 0, F_BUSY);
    add("m_stac_s",  0, 1, 8'h00, 0, 0, S_MEMOP,   0, 0, F_WR | F_AS | F_BUSY);
    add("m_stac",    0, 0, 8'h00, 0, 0, S_MEMOP,   0, 0, F_WR | F_AS | F_BUSY);
    add("m_stac_r",  1, 0, 8'h00, 0, 0, S_MEMOP,   0, 0, F_WR | F_AS | F_BUSY);
    add("post_rst",  0, 0, 8'h00, 0, 0, S_IDLE,    0, 0, 12'h000);
    add("idle_ack",  0, 0, 8'h00, 1, 0, S_IDLE,    0, 0, 12'h000);
    add("idle_rs",   1, 1, 8'h00, 0, 0, S_IDLE,    0, 0, 12'h000);
    add("idle2",     0, 0, 8'h00, 0, 0, S_IDLE,    0, 0, 12'h000);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // LDAC with memory ack arriving on the 4th cycle of the request
    v.rst_v = 0; v.z_v = 0; v.ea = 0; v.esel = 0;
    v.name = "l_start"; v.start_v = 1; v.instr_v = 8'h00; v.ack_v = 0; v.es = S_IDLE;  v.ef = F_START; step(v);
    v.name = "l_fetch"; v.start_v = 0; v.instr_v = 8'h70; v.ack_v = 1; v.es = S_FETCH; v.ef = F_FACK;  step(v);
    v.name = "l_dec";   v.instr_v = 8'h00; v.ack_v = 0; v.es = S_DECODE; v.ef = F_BUSY; step(v);
    for (int w = 0; w < 4; w++) begin
      v.name   = (w == 3) ? "l_mem_ack" : "l_mem_wait";
      v.ack_v  = (w == 3);
      v.es     = S_MEMOP;
      v.ef     = F_RD | F_AS | F_BUSY | ((w == 3) ? F_ACWE : 12'h000);
      step(v);
    end
    v.name = "l_after"; v.ack_v = 0; v.es = S_FETCH; v.ef = F_RD | F_BUSY; step(v);
    v.name = "l_f_halt"; v.instr_v = 8'hF0; v.ack_v = 1; v.es = S_FETCH; v.ef = F_FACK; step(v);
    v.name = "l_d_halt"; v.instr_v = 8'h00; v.ack_v = 0; v.es = S_DECODE; v.ef = F_BUSY; step(v);
    v.name = "l_halt";   v.es = S_HALT; v.ef = F_DONE; step(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
